// File: rtl/branch_ctrl.sv
// Branch resolution / redirect controller with optional 2-bit BHT predictor.
// Define BRANCH_PRED_EN to build the BHT; otherwise prediction is static not-taken.
`timescale 1ns/1ps
module branch_ctrl #(
  parameter int BHT_DEPTH    = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_if_pc,
  output logic        o_pred_taken,
  input  logic        i_ex_valid,
  input  logic        i_ex_is_branch,
  input  logic        i_ex_is_jump,
  input  logic [31:0] i_ex_pc,
  input  logic        i_ex_pred_taken,
  input  logic        i_ex_jump_flag,
  input  logic [31:0] i_ex_jump_addr,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_flush,
  output logic [31:0] o_mispredict_cnt
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic        redirect_q;
  logic [31:0] redirect_pc_q;
  logic [31:0] mispredict_cnt_q;

  logic        accept;
  logic        mispredict;
  logic        redirect_cond;
  logic        bht_upd;
  logic [31:0] target;

  // Anything reaching EX while flushing is wrong-path and must leave no trace.
  assign accept        = i_ex_valid & (state_q == IDLE);
  assign mispredict    = accept & i_ex_is_branch & (i_ex_jump_flag != i_ex_pred_taken);
  assign redirect_cond = mispredict | (accept & i_ex_is_jump);
  assign bht_upd       = accept & i_ex_is_branch;
  assign target        = i_ex_jump_flag ? i_ex_jump_addr : (i_ex_pc + 32'd4);

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      IDLE: begin
        if (redirect_cond) begin
          state_d     = FLUSH;
          flush_cnt_d = 3'(FLUSH_CYCLES - 1);
        end
      end
      default: begin
        if (flush_cnt_q == 3'd0) begin
          state_d = IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q          <= IDLE;
      flush_cnt_q      <= 3'd0;
      redirect_q       <= 1'b0;
      redirect_pc_q    <= 32'd0;
      mispredict_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      redirect_q  <= redirect_cond;
      if (redirect_cond) begin
        redirect_pc_q <= target;
      end
      if (mispredict && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      end
    end
  end

  assign o_redirect       = redirect_q;
  assign o_redirect_pc    = redirect_pc_q;
  assign o_flush          = (state_q == FLUSH);
  assign o_mispredict_cnt = mispredict_cnt_q;

`ifdef BRANCH_PRED_EN
  localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

  logic [1:0]       bht_q [BHT_DEPTH];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             unused_pc;

  assign if_idx    = i_if_pc[2 +: IDX_W];
  assign ex_idx    = i_ex_pc[2 +: IDX_W];
  assign unused_pc = ^i_if_pc;

  // Reset reloads every entry to weakly-not-taken.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (bht_upd) begin
      if (i_ex_jump_flag) begin
        if (bht_q[ex_idx] != 2'b11) bht_q[ex_idx] <= bht_q[ex_idx] + 2'b01;
      end else begin
        if (bht_q[ex_idx] != 2'b00) bht_q[ex_idx] <= bht_q[ex_idx] - 2'b01;
      end
    end
  end

  assign o_pred_taken = bht_q[if_idx][1];
`else
  logic        unused_upd;
  logic [31:0] unused_cfg;

  assign unused_upd   = bht_upd;
  assign unused_cfg   = i_if_pc ^ 32'(BHT_DEPTH);
  assign o_pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl; prediction expectations follow
// whether BRANCH_PRED_EN is defined for the build.
`timescale 1ns/1ps
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ifPc;
  logic        predTaken;
  logic        exValid, exIsBranch, exIsJump, exPredTaken, exJumpFlag;
  logic [31:0] exPc, exJumpAddr;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        flush;
  logic [31:0] mispredictCnt;

  int          errors = 0;
  int          checks = 0;
  logic [1:0]  modelCtr = 2'b01;
  logic [31:0] expCnt = 32'd0;

  branch_ctrl dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_if_pc         (ifPc),
    .o_pred_taken    (predTaken),
    .i_ex_valid      (exValid),
    .i_ex_is_branch  (exIsBranch),
    .i_ex_is_jump    (exIsJump),
    .i_ex_pc         (exPc),
    .i_ex_pred_taken (exPredTaken),
    .i_ex_jump_flag  (exJumpFlag),
    .i_ex_jump_addr  (exJumpAddr),
    .o_redirect      (redirect),
    .o_redirect_pc   (redirectPc),
    .o_flush         (flush),
    .o_mispredict_cnt(mispredictCnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic isBranch, input logic isJump,
                               input logic [31:0] pc, input logic pred, input logic flag,
                               input logic [31:0] addr);
    exValid     = valid;
    exIsBranch  = isBranch;
    exIsJump    = isJump;
    exPc        = pc;
    exPredTaken = pred;
    exJumpFlag  = flag;
    exJumpAddr  = addr;
  endtask

  task automatic clearEx();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Branch at 0x20 driven with whatever the reference model predicts.
  task automatic doBranch20(input logic taken, input string tag);
    logic predicted;
    logic mis;
`ifdef BRANCH_PRED_EN
    predicted = modelCtr[1];
`else
    predicted = 1'b0;
`endif
    ifPc = 32'h20;
    #1;
    checkOutput({tag, "_pred"}, {31'd0, predTaken}, {31'd0, predicted});
    mis = (predicted != taken);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h20, predicted, taken, 32'h400);
    step();
    clearEx();
    if (mis) expCnt = expCnt + 32'd1;
    checkOutput({tag, "_redirect"}, {31'd0, redirect}, {31'd0, mis});
    if (mis) checkOutput({tag, "_redirect_pc"}, redirectPc, taken ? 32'h400 : 32'h24);
    checkOutput({tag, "_cnt"}, mispredictCnt, expCnt);
    if (taken && modelCtr != 2'b11) modelCtr = modelCtr + 2'b01;
    if (!taken && modelCtr != 2'b00) modelCtr = modelCtr - 2'b01;
    if (mis) begin
      step();
      step();
    end
  endtask

  initial begin
    logic expPred;
    rst  = 1'b1;
    ifPc = 32'd0;
    clearEx();
    step();
    step();
    rst = 1'b0;

    // Reset state
    ifPc = 32'h0;        #1; checkOutput("rst_pred_0",    {31'd0, predTaken}, 32'd0);
    ifPc = 32'h3C;       #1; checkOutput("rst_pred_3c",   {31'd0, predTaken}, 32'd0);
    ifPc = 32'hFFFFFFFC; #1; checkOutput("rst_pred_fffc", {31'd0, predTaken}, 32'd0);
    checkOutput("rst_flush",    {31'd0, flush},    32'd0);
    checkOutput("rst_redirect", {31'd0, redirect}, 32'd0);
    checkOutput("rst_rpc",      redirectPc,        32'd0);
    checkOutput("rst_cnt",      mispredictCnt,     32'd0);

    // Taken branch mispredicted as not-taken
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 1'b1, 32'h80);
    step();
    clearEx();
    checkOutput("s2_redirect", {31'd0, redirect}, 32'd1);
    checkOutput("s2_rpc",      redirectPc,        32'h80);
    checkOutput("s2_flush1",   {31'd0, flush},    32'd1);
    checkOutput("s2_cnt",      mispredictCnt,     32'd1);
    ifPc = 32'h100;
    #1;
`ifdef BRANCH_PRED_EN
    expPred = 1'b1;
`else
    expPred = 1'b0;
`endif
    checkOutput("s2_pred_100", {31'd0, predTaken}, {31'd0, expPred});
    step();
    checkOutput("s2_redirect_gone", {31'd0, redirect}, 32'd0);
    checkOutput("s2_flush2",        {31'd0, flush},    32'd1);
    step();
    checkOutput("s2_flush_end",     {31'd0, flush},    32'd0);

    // Not-taken at the top of memory wraps the fall-through
    applyStimulus(1'b1, 1'b1, 1'b0, 32'hFFFFFFFC, 1'b1, 1'b0, 32'h1234);
    step();
    clearEx();
    checkOutput("s3_redirect", {31'd0, redirect}, 32'd1);
    checkOutput("s3_rpc",      redirectPc,        32'h0);
    checkOutput("s3_cnt",      mispredictCnt,     32'd2);
    step();
    step();

    // JAL followed by a wrong-path mispredict during flush
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 32'h200);
    step();
    checkOutput("s4_redirect", {31'd0, redirect}, 32'd1);
    checkOutput("s4_rpc",      redirectPc,        32'h200);
    checkOutput("s4_flush",    {31'd0, flush},    32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h64, 1'b0, 1'b1, 32'h300);
    step();
    clearEx();
    checkOutput("s4_no_second", {31'd0, redirect}, 32'd0);
    checkOutput("s4_rpc_hold",  redirectPc,        32'h200);
    checkOutput("s4_cnt",       mispredictCnt,     32'd2);
    ifPc = 32'h64;
    #1;
    checkOutput("s4_bht_64", {31'd0, predTaken}, 32'd0);
    step();
    checkOutput("s4_flush_end", {31'd0, flush},    32'd0);
    checkOutput("s4_redirect3", {31'd0, redirect}, 32'd0);
    expCnt = 32'd2;

    // Counter saturation and decay at 0x20
    doBranch20(1'b1, "t1");
    doBranch20(1'b1, "t2");
    doBranch20(1'b1, "t3");
    doBranch20(1'b1, "t4");
    doBranch20(1'b0, "n1");
    doBranch20(1'b0, "n2");
    doBranch20(1'b0, "n3");
    ifPc = 32'h20;
    #1;
    checkOutput("s5_pred_final", {31'd0, predTaken}, 32'd0);

    // Reset in the first flush cycle
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 1'b1, 32'h80);
    step();
    clearEx();
    checkOutput("s6_flush_before", {31'd0, flush}, 32'd1);
    rst = 1'b1;
    step();
    rst  = 1'b0;
    ifPc = 32'h100;
    #1;
    checkOutput("s6_flush",    {31'd0, flush},     32'd0);
    checkOutput("s6_redirect", {31'd0, redirect},  32'd0);
    checkOutput("s6_rpc",      redirectPc,         32'd0);
    checkOutput("s6_cnt",      mispredictCnt,      32'd0);
    checkOutput("s6_pred_100", {31'd0, predTaken}, 32'd0);
    step();
    checkOutput("s6_idle", {31'd0, flush}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
